// File: rtl/feedback_uart_rx.sv
// feedback_uart_rx
//   8N1 UART receiver for the game-client link. It decodes traveler feedback
//   bytes of the form {2'b00, machine, processing, hand, front, 2'b01} into the
//   sig_* status lines. It also flags framing errors and reports when feedback
//   has gone stale.
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   uart_rx        serial input (idle high), asynchronous to clk
//   sig_front      feedback bit 2
//   sig_hand       feedback bit 3
//   sig_processing feedback bit 4
//   sig_machine    feedback bit 5
//   fb_valid       1-cycle pulse: a feedback byte was decoded and sig_* updated
//   byte_valid     1-cycle pulse: a correctly framed byte was received
//   rx_byte        last correctly framed byte, held until the next one
//   frame_err      1-cycle pulse: the stop bit was sampled low and the byte was dropped
//   stale          high when no feedback byte has arrived for TIMEOUT_CYCLES
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | timing to mid start bit to confirm it is not a glitch
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | sampling the stop bit; commit the byte or flag a framing error
// WAIT_IDLE | after a framing error, wait for the line to return high

module feedback_uart_rx #(
  parameter int CLKS_PER_BIT   = 10417,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       sig_front,
  output logic       sig_hand,
  output logic       sig_processing,
  output logic       sig_machine,
  output logic       fb_valid,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       stale
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_next;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [TW-1:0] to_cnt;

  logic cnt_clr, idx_clr, shift, commit, ferr, is_fb;

  // Two-flop synchroniser. It resets to the idle level so that reset release
  // cannot be mistaken for a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    shift      = 1'b0;
    commit     = 1'b0;
    ferr       = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_clr    = 1'b1;
          idx_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          shift   = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            ferr       = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign is_fb = commit && (shreg[7:6] == 2'b00) && (shreg[1:0] == 2'b01);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (idx_clr)    bit_idx <= '0;
      else if (shift) bit_idx <= bit_idx + 3'd1;
      if (shift) shreg <= {rx_s, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_valid     <= 1'b0;
      fb_valid       <= 1'b0;
      frame_err      <= 1'b0;
      rx_byte        <= '0;
      sig_front      <= 1'b0;
      sig_hand       <= 1'b0;
      sig_processing <= 1'b0;
      sig_machine    <= 1'b0;
    end else begin
      byte_valid <= commit;
      fb_valid   <= is_fb;
      frame_err  <= ferr;
      if (commit) rx_byte <= shreg;
      if (is_fb) begin
        sig_front      <= shreg[2];
        sig_hand       <= shreg[3];
        sig_processing <= shreg[4];
        sig_machine    <= shreg[5];
      end
    end
  end

  // A feedback byte takes priority over the timeout reaching saturation on
  // the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      stale  <= 1'b1;
    end else if (is_fb) begin
      to_cnt <= '0;
      stale  <= 1'b0;
    end else if (to_cnt >= TO_MAX - TW'(1)) begin
      to_cnt <= TO_MAX;
      stale  <= 1'b1;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule
